// File: rtl/ibex_csr_err_pkg.sv
// Shared types and helpers for the shadowed-CSR error controller.
// popcount works on vectors up to PopMaxW bits; callers zero-extend narrower vectors.
package ibex_csr_err_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SCAN,
        REPORT
    } csr_err_state_e;

    localparam int unsigned PopMaxW = 64;
    localparam int unsigned PopCntW = 7;

    function automatic logic [PopCntW-1:0] popcount(input logic [PopMaxW-1:0] vec);
        logic [PopCntW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < PopMaxW; i++) begin
            cnt = cnt + PopCntW'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ibex_csr_err_sat_cnt.sv
// Saturating event counter: adds the popcount of an N-bit pulse vector every cycle.
// One-cycle update latency, no backpressure; clr wins over that cycle's pulses.
module ibex_csr_err_sat_cnt
    import ibex_csr_err_pkg::*;
#(
    parameter int unsigned Width = 16,
    parameter int unsigned N     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [N-1:0]     pulse,
    output logic [Width-1:0] cnt
);

    // One spare bit above the largest possible sum so the addition never wraps.
    localparam int unsigned SumW = Width + $clog2(N) + 1;
    localparam logic [SumW-1:0] MaxVal = {{(SumW-Width){1'b0}}, {Width{1'b1}}};

    logic [PopMaxW-1:0] pulse_ext;
    logic [SumW-1:0]    sum;

    assign pulse_ext = PopMaxW'(pulse);
    assign sum       = SumW'(cnt) + SumW'(popcount(pulse_ext));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (sum > MaxVal) begin
            cnt <= {Width{1'b1}};
        end else begin
            cnt <= sum[Width-1:0];
        end
    end

endmodule

// File: rtl/ibex_csr_err_ctrl.sv
// Scans a bank of shadowed CSRs for mismatches, reports them over req/ack and counts error pulses.
// Optional IBEX_CSR_ERR_TS_EN adds a cycle timestamp (alert_ts_o) captured when a report starts.
module ibex_csr_err_ctrl
    import ibex_csr_err_pkg::*;
#(
    parameter  int unsigned NumCsr      = 8,
    parameter  int unsigned CntWidth    = 16,
    parameter  int unsigned ScanPeriod  = 1024,
    parameter  int unsigned AlertThresh = 4,
    localparam int unsigned IdxW        = $clog2(NumCsr)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumCsr-1:0]   csr_rd_error_i,
    input  logic [NumCsr-1:0]   csr_maj_err_i,
    input  logic [NumCsr-1:0]   csr_min_err_i,
    input  logic [NumCsr-1:0]   csr_scrub_i,
    input  logic                scan_en_i,
    input  logic                clr_i,
    output logic [IdxW-1:0]     scan_idx_o,
    output logic                scan_busy_o,
    output logic                alert_req_o,
    output logic [IdxW-1:0]     alert_idx_o,
`ifdef IBEX_CSR_ERR_TS_EN
    output logic [31:0]         alert_ts_o,
`endif
    input  logic                alert_ack_i,
    output logic [CntWidth-1:0] maj_cnt_o,
    output logic [CntWidth-1:0] min_cnt_o,
    output logic [CntWidth-1:0] scrub_cnt_o,
    output logic                fatal_o
);

    localparam int unsigned TimerW = $clog2(ScanPeriod);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(ScanPeriod - 1);
    localparam logic [IdxW-1:0]   LastIdx   = IdxW'(NumCsr - 1);
    localparam logic [CntWidth-1:0] Thresh  = CntWidth'(AlertThresh);

    csr_err_state_e    state;
    logic [TimerW-1:0] timer;
    logic              alert_hit;

    assign alert_hit = (state == SCAN) && csr_rd_error_i[scan_idx_o];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            timer       <= '0;
            scan_idx_o  <= '0;
            scan_busy_o <= 1'b0;
            alert_req_o <= 1'b0;
            alert_idx_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (scan_en_i) begin
                        state <= WAIT;
                        timer <= '0;
                    end
                end
                WAIT: begin
                    if (!scan_en_i) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == TimerLast) begin
                        state       <= SCAN;
                        timer       <= '0;
                        scan_idx_o  <= '0;
                        scan_busy_o <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                // scan_en_i is deliberately not looked at until the sweep finishes.
                SCAN: begin
                    if (alert_hit) begin
                        state       <= REPORT;
                        alert_req_o <= 1'b1;
                        alert_idx_o <= scan_idx_o;
                    end else if (scan_idx_o == LastIdx) begin
                        state       <= WAIT;
                        timer       <= '0;
                        scan_busy_o <= 1'b0;
                    end else begin
                        scan_idx_o <= scan_idx_o + 1'b1;
                    end
                end
                REPORT: begin
                    if (alert_ack_i) begin
                        alert_req_o <= 1'b0;
                        if (scan_idx_o == LastIdx) begin
                            state       <= WAIT;
                            timer       <= '0;
                            scan_busy_o <= 1'b0;
                        end else begin
                            state      <= SCAN;
                            scan_idx_o <= scan_idx_o + 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    timer       <= '0;
                    scan_busy_o <= 1'b0;
                    alert_req_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef IBEX_CSR_ERR_TS_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_cnt  <= '0;
            alert_ts_o <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (alert_hit) begin
                alert_ts_o <= cycle_cnt;
            end
        end
    end
`endif

    ibex_csr_err_sat_cnt #(.Width(CntWidth), .N(NumCsr)) u_maj_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (clr_i),
        .pulse (csr_maj_err_i),
        .cnt   (maj_cnt_o)
    );

    ibex_csr_err_sat_cnt #(.Width(CntWidth), .N(NumCsr)) u_min_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (clr_i),
        .pulse (csr_min_err_i),
        .cnt   (min_cnt_o)
    );

    ibex_csr_err_sat_cnt #(.Width(CntWidth), .N(NumCsr)) u_scrub_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (clr_i),
        .pulse (csr_scrub_i),
        .cnt   (scrub_cnt_o)
    );

    // Sticky: only reset clears it, clr_i leaves it alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fatal_o <= 1'b0;
        end else if (maj_cnt_o >= Thresh) begin
            fatal_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ibex_csr_err_ctrl.sv
// Bench for ibex_csr_err_ctrl: directed scenarios plus randomized traffic against a cycle-level model.
module tb_ibex_csr_err_ctrl;

    localparam int N   = 8;
    localparam int CW  = 4;
    localparam int P   = 16;
    localparam int TH  = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam int MIdle = 0;
    localparam int MWait = 1;
    localparam int MScan = 2;
    localparam int MRep  = 3;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  rd_err, maj, min, scr;
    logic          scan_en, clr, ack;
    logic [2:0]    scan_idx, alert_idx;
    logic          busy, req, fatal;
    logic [CW-1:0] maj_cnt, min_cnt, scr_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_maj, m_min, m_scr;
    bit m_fatal;
    int m_mode, m_cyc, m_scan_at, m_idx, m_aidx;
    bit m_req;

    ibex_csr_err_ctrl #(.NumCsr(N), .CntWidth(CW), .ScanPeriod(P), .AlertThresh(TH)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .csr_rd_error_i (rd_err),
        .csr_maj_err_i  (maj),
        .csr_min_err_i  (min),
        .csr_scrub_i    (scr),
        .scan_en_i      (scan_en),
        .clr_i          (clr),
        .scan_idx_o     (scan_idx),
        .scan_busy_o    (busy),
        .alert_req_o    (req),
        .alert_idx_o    (alert_idx),
        .alert_ack_i    (ack),
        .maj_cnt_o      (maj_cnt),
        .min_cnt_o      (min_cnt),
        .scrub_cnt_o    (scr_cnt),
        .fatal_o        (fatal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat_add(input int c, input logic [N-1:0] v);
        int s;
        s = c + $countones(v);
        return (s > CMAX) ? CMAX : s;
    endfunction

    task automatic model_reset();
        m_maj = 0; m_min = 0; m_scr = 0; m_fatal = 0;
        m_mode = MIdle; m_cyc = 0; m_scan_at = 0; m_idx = 0; m_aidx = 0; m_req = 0;
    endtask

    // Scans are scheduled by absolute edge number: ScanPeriod edges after entering WAIT.
    task automatic model_step();
        m_cyc++;
        m_fatal = m_fatal || (m_maj >= TH);
        if (clr) begin
            m_maj = 0; m_min = 0; m_scr = 0;
        end else begin
            m_maj = sat_add(m_maj, maj);
            m_min = sat_add(m_min, min);
            m_scr = sat_add(m_scr, scr);
        end
        case (m_mode)
            MIdle: if (scan_en) begin m_mode = MWait; m_scan_at = m_cyc + P; end
            MWait: begin
                if (!scan_en) m_mode = MIdle;
                else if (m_cyc == m_scan_at) begin m_mode = MScan; m_idx = 0; end
            end
            MScan: begin
                if (rd_err[m_idx]) begin m_mode = MRep; m_req = 1; m_aidx = m_idx; end
                else if (m_idx == N-1) begin m_mode = MWait; m_scan_at = m_cyc + P; end
                else m_idx++;
            end
            default: begin
                if (ack) begin
                    m_req = 0;
                    if (m_idx == N-1) begin m_mode = MWait; m_scan_at = m_cyc + P; end
                    else begin m_mode = MScan; m_idx++; end
                end
            end
        endcase
    endtask

    task automatic check_all();
        chk("busy", busy, (m_mode == MScan || m_mode == MRep) ? 1 : 0);
        chk("req", req, m_req ? 1 : 0);
        if (m_mode == MScan || m_mode == MRep) chk("scan_idx", scan_idx, m_idx);
        if (m_req) chk("alert_idx", alert_idx, m_aidx);
        chk("maj_cnt", maj_cnt, m_maj);
        chk("min_cnt", min_cnt, m_min);
        chk("scrub_cnt", scr_cnt, m_scr);
        chk("fatal", fatal, m_fatal ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_req(input string nm, input int budget);
        int n;
        n = 0;
        while (!req && n < budget) begin
            tick();
            n++;
        end
        if (!req) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout waiting for alert_req, got 0 expected 1", nm);
        end
    endtask

    task automatic async_reset_pulse();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req", req, 0);
        chk("arst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int exp_min [5] = '{4, 8, 12, 15, 15};
        rst_n = 1'b0;
        rd_err = '0; maj = '0; min = '0; scr = '0;
        scan_en = 1'b0; clr = 1'b0; ack = 1'b0;
        model_reset();
        #23;
        rst_n = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 0 || i == 99) begin
                chk("t1_busy", busy, 0);
                chk("t1_req", req, 0);
                chk("t1_maj", maj_cnt, 0);
                chk("t1_fatal", fatal, 0);
            end
        end

        // 2: mismatch at index 5, acked three cycles after req rises
        scan_en = 1'b1;
        rd_err  = 8'h20;
        wait_req("t2_req", 60);
        chk("t2_alert_idx", alert_idx, 5);
        tick();
        chk("t2_req_hold1", req, 1);
        tick();
        chk("t2_req_hold2", req, 1);
        ack = 1'b1;
        tick();
        chk("t2_req_drop", req, 0);
        chk("t2_resume_idx", scan_idx, 6);
        chk("t2_busy", busy, 1);
        ack = 1'b0;
        rd_err = '0;
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        chk("t2_sweep_end", busy, 0);
        scan_en = 1'b0;
        tick();

        // 3: eight major pulses at once
        clr = 1'b1; tick(); clr = 1'b0;
        maj = 8'hFF;
        tick();
        chk("t3_maj", maj_cnt, 8);
        chk("t3_fatal_early", fatal, 0);
        maj = '0;
        tick();
        chk("t3_fatal", fatal, 1);

        // 4: minor counter saturation
        min = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_min_sat", min_cnt, exp_min[i]);
        end
        min = '0;

        // 5: clear beats simultaneous pulses, fatal stays
        scr = 8'h01; tick(); chk("t5_scr_pre", scr_cnt, 1);
        scr = 8'h03; clr = 1'b1;
        tick();
        chk("t5_scr_clr", scr_cnt, 0);
        chk("t5_min_clr", min_cnt, 0);
        chk("t5_fatal_kept", fatal, 1);
        scr = '0; clr = 1'b0;

        // 6: reset during REPORT
        scan_en = 1'b1;
        rd_err  = 8'h01;
        wait_req("t6_req", 60);
        async_reset_pulse();
        scan_en = 1'b0;
        rd_err  = '0;
        tick();
        chk("t6_busy", busy, 0);
        chk("t6_req", req, 0);
        chk("t6_maj", maj_cnt, 0);
        chk("t6_min", min_cnt, 0);
        chk("t6_fatal", fatal, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                async_reset_pulse();
            end else begin
                scan_en = ($urandom_range(0, 15) != 0);
                rd_err  = N'($urandom & $urandom & $urandom);
                ack     = ($urandom_range(0, 2) == 0);
                clr     = ($urandom_range(0, 63) == 0);
                maj = ($urandom_range(0, 7) == 0) ? N'($urandom & $urandom) : '0;
                min = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom) : '0;
                scr = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom & $urandom) : '0;
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
